// File: rtl/axil_pkg.sv
// Shared AXI-Lite interconnect configuration.
// NUMBER_MASTER is common to both arbiters; each direction picks its own scheme.
package axil_pkg;
    localparam int NUMBER_MASTER = 4;
    localparam bit ARBITER_RD    = 1'b1;  // 1 = round robin, 0 = fixed priority
    localparam bit ARBITER_WR    = 1'b1;  // 1 = round robin, 0 = fixed priority
endpackage

// File: rtl/axil_arbiter_wr_if.sv
// Write-arbiter bus bundle: master requests and handshakes in, grant out.
// 'slave' is the arbiter's view; 'master' is the side that drives requests and handshakes.
interface axil_arbiter_wr_if #(
    parameter int NUMBER_MASTER = axil_pkg::NUMBER_MASTER
);
    localparam int IDX_W = $clog2(NUMBER_MASTER);

    logic [NUMBER_MASTER-1:0] request_wr;
    logic [NUMBER_MASTER-1:0] grant_wr;
    logic [IDX_W-1:0]         grant_idx_wr;
    logic [NUMBER_MASTER-1:0] m_axil_awvalid;
    logic [NUMBER_MASTER-1:0] m_axil_wvalid;
    logic [NUMBER_MASTER-1:0] m_axil_bready;
    logic                     s_axil_awready;
    logic                     s_axil_wready;
    logic                     s_axil_bvalid;

    modport master (
        output request_wr, m_axil_awvalid, m_axil_wvalid, m_axil_bready,
        output s_axil_awready, s_axil_wready, s_axil_bvalid,
        input  grant_wr, grant_idx_wr
    );

    modport slave (
        input  request_wr, m_axil_awvalid, m_axil_wvalid, m_axil_bready,
        input  s_axil_awready, s_axil_wready, s_axil_bvalid,
        output grant_wr, grant_idx_wr
    );
endinterface

// File: rtl/axil_rr_pick.sv
// Combinational winner selection: request vector + last-granted pointer -> one-hot and index.
// Shared by the read and write arbiters.
module axil_rr_pick #(
    parameter int NUMBER_MASTER = axil_pkg::NUMBER_MASTER,
    parameter bit ROUND_ROBIN   = 1'b1,
    localparam int IDX_W        = $clog2(NUMBER_MASTER)
) (
    input  logic [NUMBER_MASTER-1:0] i_request,
    input  logic [IDX_W-1:0]         i_ptr,
    output logic [NUMBER_MASTER-1:0] o_grant,
    output logic [IDX_W-1:0]         o_idx
);
    logic [NUMBER_MASTER-1:0] w_mask;
    logic [NUMBER_MASTER-1:0] w_masked;
    logic [NUMBER_MASTER-1:0] w_sel;
    logic [NUMBER_MASTER-1:0] w_one;

    // Shift amount is widened so ptr = N-1 yields an empty mask instead of wrapping.
    assign w_mask   = {NUMBER_MASTER{1'b1}} << (32'(i_ptr) + 32'd1);
    assign w_masked = i_request & w_mask;
    assign w_one    = {{(NUMBER_MASTER-1){1'b0}}, 1'b1};
    assign w_sel    = (ROUND_ROBIN && (w_masked != '0)) ? w_masked : i_request;
    assign o_grant  = w_sel & (~w_sel + w_one);

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < NUMBER_MASTER; i++)
            if (o_grant[i]) o_idx = IDX_W'(i);
    end
endmodule

// File: rtl/axil_arbiter_wr.sv
// AXI-Lite write-channel arbiter: grants one master and holds it through AW, W and B.
// The grant drops on the granted master's B handshake, leaving one idle cycle before the next grant.
module axil_arbiter_wr
    import axil_pkg::*;
#(
    parameter int NUMBER_MASTER = axil_pkg::NUMBER_MASTER,
    parameter bit ARBITER_WR    = axil_pkg::ARBITER_WR,
    localparam int IDX_W        = $clog2(NUMBER_MASTER)
) (
    input  logic             aclk,
    input  logic             aresetn,
    axil_arbiter_wr_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ADDR_DATA, RESP} state_t;

    state_t                   r_state, w_state;
    logic [NUMBER_MASTER-1:0] r_grant, w_grant;
    logic [IDX_W-1:0]         r_idx, w_idx;
    logic [IDX_W-1:0]         r_ptr, w_ptr;
    logic                     r_aw_done, w_aw_done;
    logic                     r_w_done, w_w_done;

    logic [NUMBER_MASTER-1:0] w_pick_grant;
    logic [IDX_W-1:0]         w_pick_idx;
    logic                     w_aw_now, w_w_now, w_b_hs;

    axil_rr_pick #(
        .NUMBER_MASTER (NUMBER_MASTER),
        .ROUND_ROBIN   (ARBITER_WR)
    ) u_pick (
        .i_request (bus.request_wr),
        .i_ptr     (r_ptr),
        .o_grant   (w_pick_grant),
        .o_idx     (w_pick_idx)
    );

    // Only the granted master's handshakes count.
    assign w_aw_now = r_aw_done | (bus.m_axil_awvalid[r_idx] & bus.s_axil_awready);
    assign w_w_now  = r_w_done  | (bus.m_axil_wvalid[r_idx]  & bus.s_axil_wready);
    assign w_b_hs   = bus.s_axil_bvalid & bus.m_axil_bready[r_idx];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_idx     <= '0;
            r_ptr     <= IDX_W'(NUMBER_MASTER - 1);
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_grant   <= w_grant;
            r_idx     <= w_idx;
            r_ptr     <= w_ptr;
            r_aw_done <= w_aw_done;
            r_w_done  <= w_w_done;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_grant   = r_grant;
        w_idx     = r_idx;
        w_ptr     = r_ptr;
        w_aw_done = r_aw_done;
        w_w_done  = r_w_done;
        case (r_state)
            IDLE: begin
                if (|bus.request_wr) begin
                    w_grant = w_pick_grant;
                    w_idx   = w_pick_idx;
                    w_ptr   = w_pick_idx;
                    w_state = ADDR_DATA;
                end
            end
            ADDR_DATA: begin
                if (w_aw_now && w_w_now) begin
                    w_aw_done = 1'b0;
                    w_w_done  = 1'b0;
                    w_state   = RESP;
                end else begin
                    w_aw_done = w_aw_now;
                    w_w_done  = w_w_now;
                end
            end
            RESP: begin
                if (w_b_hs) begin
                    w_grant = '0;
                    w_idx   = '0;
                    w_state = IDLE;
                end
            end
            default: begin
                w_grant   = '0;
                w_idx     = '0;
                w_aw_done = 1'b0;
                w_w_done  = 1'b0;
                w_state   = IDLE;
            end
        endcase
    end

    assign bus.grant_wr     = r_grant;
    assign bus.grant_idx_wr = r_idx;
endmodule

// File: doc/axil_arbiter_wr.md
Name: axil_arbiter_wr

Overview:
Write-channel arbiter for the AXI-Lite interconnect. It is the write-direction counterpart of the read arbiter. It selects one of NUMBER_MASTER masters requesting a write and holds that grant through the AW, W and B phases. The grant is released only on the B handshake of the granted master. Its grant_wr/grant_idx_wr outputs drive the AW/W/B muxes and demuxes between the masters and the shared slave port.

Parameters:
NUMBER_MASTER, axil_pkg::NUMBER_MASTER (4), number of masters; must be >= 2.
ARBITER_WR, axil_pkg::ARBITER_WR (1), 1 = round robin, 0 = fixed priority (lowest index wins).

Ports:
aclk  in  1  clock; all logic on rising edge
aresetn  in  1  asynchronous active-low reset
request_wr  in  NUMBER_MASTER  per-master write request; must be held high until its B handshake
grant_wr  out  NUMBER_MASTER  one-hot grant, registered
grant_idx_wr  out  $clog2(NUMBER_MASTER)  binary index of the granted master; 0 when idle
m_axil_awvalid  in  NUMBER_MASTER  AWVALID from each master
m_axil_wvalid  in  NUMBER_MASTER  WVALID from each master
s_axil_awready  in  1  AWREADY from the slave
s_axil_wready  in  1  WREADY from the slave
s_axil_bvalid  in  1  BVALID from the slave
m_axil_bready  in  NUMBER_MASTER  BREADY from each master

Behaviour:
- Reset (async assert, sync release): state=IDLE; grant_wr=0; grant_idx_wr=0; aw_done=0; w_done=0; last-granted pointer=NUMBER_MASTER-1, so the first round-robin search starts at master 0. Reset asserted mid-transaction clears the grant immediately and without a clock edge.
- State machine with states IDLE, ADDR_DATA and RESP. Notation: g = grant_idx_wr.
- IDLE:
  - If |request_wr = 0, stay in IDLE.
  - Otherwise, on the next edge: grant_wr <= next_grant, grant_idx_wr <= its index, pointer <= that index, state <= ADDR_DATA.
  - Latency: a request sampled at edge N gives grant_wr valid after edge N (a registered, 1-cycle grant).
- ADDR_DATA:
  - aw_done sets on (m_axil_awvalid[g] & s_axil_awready).
  - w_done sets on (m_axil_wvalid[g] & s_axil_wready).
  - The AW and W handshakes may occur in either order or in the same cycle.
  - When both are complete (already set, or completing this cycle), go to RESP and clear both flags.
- RESP:
  - On (s_axil_bvalid & m_axil_bready[g]): grant_wr <= 0, grant_idx_wr <= 0, state <= IDLE.
  - A B handshake in the same cycle that AW/W complete is not possible, because the slave issues B only after the address and data phases.
- Every transaction has at least one IDLE cycle between grants, so back-to-back grants are separated by one idle clock.
- Round robin (ARBITER_WR=1):
  - mask = all-ones << (pointer+1), computed at NUMBER_MASTER width; pointer = N-1 gives mask=0.
  - masked = request_wr & mask.
  - next_grant = the lowest set bit of masked if masked != 0, else the lowest set bit of request_wr. Use the x & -x idiom at NUMBER_MASTER width.
- Fixed priority (ARBITER_WR=0): next_grant is the lowest-index set bit of request_wr; the pointer is unused.
- Handshake inputs of non-granted masters are ignored in every state.
- request_wr changes while granted are ignored; the grant is held until the B handshake even if the request drops.
- grant_wr is always one-hot or zero. grant_idx_wr always matches grant_wr.
- Simultaneous requests in IDLE are resolved by the selected scheme in that same cycle.

Decomposition:
- axil_pkg gains ARBITER_WR next to ARBITER_RD. NUMBER_MASTER stays shared.
- The state enum (IDLE, ADDR_DATA, RESP) is local to the module.
- One sub-module is natural: axil_rr_pick (combinational request, pointer -> one-hot and index), reusable by the read arbiter later.

Test Plan (NUMBER_MASTER=4):
1. Reset and single request:
   - Stimulus: request_wr=0100. AW and W complete in the same cycle; B comes 3 cycles later.
   - Required: grant_wr=0100 and grant_idx_wr=2 one cycle after the request. The grant is held through AW/W/B and is 0 the cycle after bvalid&bready[2].
2. AW/W ordering: AW handshake at cycle 2 and W handshake at cycle 5 → state reaches RESP only after cycle 5. A bvalid asserted early with bready=0 must not release the grant.
3. Round robin rotation:
   - Stimulus: request_wr=1111 held, with each transaction completed.
   - Required: grants follow 0001, 0010, 0100, 1000, 0001, each separated by one idle cycle.
4. Round robin wrap and skip:
   - Stimulus: last grant 1000, then request_wr=0110.
   - Required: the next grant is 0010, then 0100.
5. Fixed priority (ARBITER_WR=0):
   - Stimulus: request_wr=1010 held.
   - Required: master 1 is granted repeatedly and master 3 starves. Foreign bvalid/bready from master 3 is ignored.
6. Reset mid-operation:
   - Stimulus: deassert aresetn asynchronously while in RESP with grant 0100.
   - Required: grant_wr=0 immediately. After release with request_wr=1000, the first grant is 1000 and the pointer restarts from master 0.
